// File: rtl/i2s_sample_tx.sv
//------------------------------------------------------------------------------
// Module  : i2s_sample_tx
// Brief   : Single-sample holding register feeding a 32-slot I2S serialiser
//           (one-bit delay, MSB first). Optional macro I2S_MONO_DUP_EN copies
//           the sample into the right slot; otherwise the right slot is zero.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module i2s_sample_tx #(
  parameter int BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [15:0] in_sample,
  output logic        ready,
  output logic        ou_bclk,
  output logic        ou_lrclk,
  output logic        ou_sdata,
  output logic        ou_underrun
);

  logic [7:0]  div;
  logic [4:0]  slot;
  logic [31:0] shreg;
  logic [15:0] hold;
  logic        full;

  logic        toggle;
  logic        fall;
  logic        load;
  logic [4:0]  slot_nxt;
  logic [15:0] right_word;

  always_comb begin
    toggle   = (div == 8'(BCLK_DIV - 1));
    fall     = toggle && ou_bclk;
    slot_nxt = slot + 5'd1;
    load     = fall && (slot_nxt == 5'd1);
  end

`ifdef I2S_MONO_DUP_EN
  assign right_word = hold;
`else
  assign right_word = 16'h0000;
`endif

  assign ready       = !full && !rst;
  assign ou_underrun = load && !full && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= 8'd0;
      ou_bclk  <= 1'b0;
      ou_lrclk <= 1'b0;
      ou_sdata <= 1'b0;
      slot     <= 5'd31;
      shreg    <= 32'd0;
      hold     <= 16'd0;
      full     <= 1'b0;
    end else begin
      div <= toggle ? 8'd0 : div + 8'd1;
      if (toggle) begin
        ou_bclk <= ~ou_bclk;
      end

      if (fall) begin
        slot     <= slot_nxt;
        ou_lrclk <= slot_nxt[4];
        // Slot 1 emits the new frame's MSB directly; the rest is shifted out,
        // leaving the right LSB for slot 0 of the following frame.
        if (load) begin
          if (full) begin
            shreg    <= {hold, right_word} << 1;
            ou_sdata <= hold[15];
          end else begin
            shreg    <= 32'd0;
            ou_sdata <= 1'b0;
          end
        end else begin
          ou_sdata <= shreg[31];
          shreg    <= shreg << 1;
        end
      end

      if (valid && ready) begin
        hold <= in_sample;
        full <= 1'b1;
      end else if (load) begin
        full <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2s_sample_tx.sv
//------------------------------------------------------------------------------
// Module  : tb_i2s_sample_tx
// Brief   : Randomised bench for i2s_sample_tx against a slot/frame-level model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2s_sample_tx;

  localparam int N = 2;
  localparam int P = 2 * N;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] in_sample;
  logic        ready;
  logic        ou_bclk;
  logic        ou_lrclk;
  logic        ou_sdata;
  logic        ou_underrun;

  int errors = 0;
  int checks = 0;

  // Model state: e counts clk edges since reset release.
  int unsigned e;
  logic        m_full;
  logic [15:0] m_hold;
  logic [31:0] m_frame;
  logic        m_sdata;
  logic        last_load;
  logic        accepted;

  i2s_sample_tx #(.BCLK_DIV(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .in_sample  (in_sample),
    .ready      (ready),
    .ou_bclk    (ou_bclk),
    .ou_lrclk   (ou_lrclk),
    .ou_sdata   (ou_sdata),
    .ou_underrun(ou_underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int cur_slot();
    int f;
    f = int'(e / P);
    return (f == 0) ? 31 : (f - 1) % 32;
  endfunction

  function automatic logic is_fall();
    return ((e + 1) % P) == 0;
  endfunction

  function automatic logic is_load();
    return is_fall() && ((int'(e / P) % 32) == 1);
  endfunction

  function automatic logic [15:0] right_of(input logic [15:0] s);
`ifdef I2S_MONO_DUP_EN
    return s;
`else
    return 16'h0000;
`endif
  endfunction

  // One clk cycle: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic cycle(input logic r, input logic v, input logic [15:0] d);
    logic ld;
    int   s;
    @(negedge clk);
    rst = r; valid = v; in_sample = d;
    #1;
    ld = is_load();
    check("bclk",     32'(ou_bclk),     32'(((e / N) % 2) == 1));
    check("lrclk",    32'(ou_lrclk),    32'((e >= P) && (cur_slot() >= 16)));
    check("sdata",    32'(ou_sdata),    32'(m_sdata));
    check("ready",    32'(ready),       32'(!m_full && !r));
    check("underrun", 32'(ou_underrun), 32'(ld && !m_full && !r));
    accepted = 1'b0;
    if (r) begin
      e = 0; m_full = 1'b0; m_frame = 32'd0; m_sdata = 1'b0;
      last_load = 1'b0;
    end else begin
      accepted = v && !m_full;
      if (is_fall()) begin
        s = int'(e / P) % 32;
        if (s == 1) begin
          m_frame = m_full ? {m_hold, right_of(m_hold)} : 32'd0;
          m_full  = 1'b0;
        end
        m_sdata = (s == 0) ? m_frame[0] : m_frame[32 - s];
      end
      if (accepted) begin
        m_hold = d;
        m_full = 1'b1;
      end
      last_load = ld;
      e++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0);
  endtask

  // Drive one sample until accepted; records whether acceptance followed a load.
  task automatic push(input logic [15:0] d, input string tag, input logic expect_after_load);
    int  budget;
    logic prev_load;
    budget = 0;
    accepted = 1'b0;
    prev_load = 1'b0;
    while (!accepted && budget < 400) begin
      prev_load = last_load;
      cycle(1'b0, 1'b1, d);
      budget++;
    end
    check({tag, "_accepted"}, 32'(accepted), 32'd1);
    if (expect_after_load) check({tag, "_after_load"}, 32'(prev_load), 32'd1);
  endtask

  initial begin
    int budget;
    int p;
    rst = 1'b1; valid = 1'b0; in_sample = 16'h0;
    e = 0; m_full = 1'b0; m_hold = 16'h0; m_frame = 32'd0; m_sdata = 1'b0;
    last_load = 1'b0; accepted = 1'b0;

    // Reset, then a single sample ahead of the first load.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 16'hA5F0);
    check("single_accepted", 32'(accepted), 32'd1);
    idle(2 * 32 * P);

    // Back-pressure: second sample only enters after the first is loaded.
    push(16'h1234, "bp1", 1'b0);
    push(16'h8000, "bp2", 1'b1);
    idle(32 * P);

    // Underrun: a full frame with no samples.
    idle(2 * 32 * P);
    check("underrun_ready", 32'(ready), 32'd1);

    // Reset mid-frame while holding a sample.
    push(16'h5A5A, "mid", 1'b0);
    budget = 0;
    while (!(cur_slot() == 10 && m_full) && budget < 400) begin
      cycle(1'b0, 1'b0, 16'h0);
      budget++;
    end
    check("mid_reach_slot10", 32'(budget < 400), 32'd1);
    cycle(1'b1, 1'b0, 16'h0);
    idle(2 * 32 * P);

    // Sample arriving in the exact load cycle while empty.
    budget = 0;
    while (!(is_load() && !m_full) && budget < 400) begin
      cycle(1'b0, 1'b0, 16'h0);
      budget++;
    end
    check("simul_reach_load", 32'(budget < 400), 32'd1);
    cycle(1'b0, 1'b1, 16'h7FFF);
    check("simul_accepted", 32'(accepted), 32'd1);
    idle(2 * 32 * P);

    // Randomised traffic with varying load and occasional resets.
    for (int blk = 0; blk < 6; blk++) begin
      p = (blk % 3 == 0) ? 10 : (blk % 3 == 1) ? 50 : 95;
      for (int i = 0; i < 500; i++) begin
        cycle(($urandom % 700) == 0, ($urandom % 100) < p, 16'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
